// File: rtl/approx_mul_arbiter_pkg.sv
// Shared widths, stage entry type and partial-product mask helper for the
// approximate-multiplier arbiter.
package approx_mul_arbiter_pkg;

    localparam int OPND_W      = 8;
    localparam int PROD_W      = 16;
    localparam int NUM_REQ_DEF = 4;
    localparam int MAX_ID_W    = 3;
    // Partial products whose column weight (i+j) is below this are dropped
    localparam int TRUNC_COLS  = 4;

    typedef struct packed {
        logic [OPND_W-1:0]   x;
        logic [OPND_W-1:0]   y;
        logic [MAX_ID_W-1:0] id;
    } stage_entry_t;

    function automatic logic [OPND_W-1:0] row_mask(input int row);
        logic [OPND_W-1:0] m;
        for (int i = 0; i < OPND_W; i++) begin
            m[i] = ((i + row) >= TRUNC_COLS) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/approx_mul_arbiter_mul8u.sv
// Purely combinational 8x8 unsigned truncated multiplier: partial-product bits
// in the lowest TRUNC_COLS columns are discarded.
module approx_mul8u
    import approx_mul_arbiter_pkg::*;
(
    input  logic [OPND_W-1:0] x,
    input  logic [OPND_W-1:0] y,
    output logic [PROD_W-1:0] z
);

    logic [PROD_W-1:0] acc_s;

    // Accumulate masked rows of the partial-product array
    always_comb begin
        acc_s = {PROD_W{1'b0}};
        for (int j = 0; j < OPND_W; j++) begin
            if (y[j]) begin
                acc_s = acc_s + (PROD_W'(x & row_mask(j)) << j);
            end else begin
                acc_s = acc_s;
            end
        end
    end

    assign z = acc_s;

endmodule

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter feeding one shared approximate multiplier.
// Define APPROX_MUL_ARBITER_PIPE_EN to add an elastic operand stage (latency 2).
module approx_mul_arbiter
    import approx_mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPND_W-1:0] req_x,
    input  logic [NUM_REQ*OPND_W-1:0] req_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PROD_W-1:0]         out_z,
    output logic [ID_W-1:0]           out_id,
    output logic                      busy
);

    logic [ID_W-1:0]   last_grant_r, last_grant_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
    logic [PROD_W-1:0] out_z_r, out_z_nxt_s;
    logic [ID_W-1:0]   out_id_r, out_id_nxt_s;
    logic              busy_r, busy_nxt_s;

    logic [ID_W-1:0]   gnt_idx_s;
    logic              gnt_found_s;
    logic [OPND_W-1:0] gnt_x_s, gnt_y_s;
    logic              result_can_s, issue_can_s, accept_s;
    stage_entry_t      core_in_s;
    logic              core_valid_s;
    logic [PROD_W-1:0] core_z_s;
    int                cand_s;

    // Round-robin search starting just after the last accepted requester
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = last_grant_r;
        cand_s      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = int'(last_grant_r) + k;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_found_s && req_valid[cand_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = ID_W'(cand_s);
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Operand mux for the winner and the one-hot ready vector
    always_comb begin
        gnt_x_s   = {OPND_W{1'b0}};
        gnt_y_s   = {OPND_W{1'b0}};
        req_ready = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx_s == ID_W'(i)) begin
                gnt_x_s = req_x[i*OPND_W +: OPND_W];
                gnt_y_s = req_y[i*OPND_W +: OPND_W];
            end else begin
                gnt_x_s = gnt_x_s;
                gnt_y_s = gnt_y_s;
            end
            req_ready[i] = accept_s && (gnt_idx_s == ID_W'(i));
        end
    end

    assign result_can_s = !out_valid_r || out_ready;
    // Reset gating keeps ready low while rst_n is held
    assign accept_s     = rst_n && gnt_found_s && issue_can_s;

`ifdef APPROX_MUL_ARBITER_PIPE_EN
    logic         op_valid_r, op_valid_nxt_s;
    stage_entry_t op_r, op_nxt_s;

    assign issue_can_s  = !op_valid_r || result_can_s;
    assign core_in_s    = op_r;
    assign core_valid_s = op_valid_r;

    // Operand stage next state: load on accept, hold while the result stage is stalled
    always_comb begin
        op_valid_nxt_s = op_valid_r;
        op_nxt_s       = op_r;
        if (issue_can_s) begin
            op_valid_nxt_s = accept_s;
            if (accept_s) begin
                op_nxt_s = '{x: gnt_x_s, y: gnt_y_s, id: MAX_ID_W'(gnt_idx_s)};
            end else begin
                op_nxt_s = op_r;
            end
        end else begin
            op_valid_nxt_s = op_valid_r;
            op_nxt_s       = op_r;
        end
    end

    // Operand stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_r <= 1'b0;
            op_r       <= '0;
        end else begin
            op_valid_r <= op_valid_nxt_s;
            op_r       <= op_nxt_s;
        end
    end

    assign busy_nxt_s = out_valid_nxt_s | op_valid_nxt_s;
`else
    assign issue_can_s  = result_can_s;
    assign core_in_s    = '{x: gnt_x_s, y: gnt_y_s, id: MAX_ID_W'(gnt_idx_s)};
    assign core_valid_s = accept_s;
    assign busy_nxt_s   = out_valid_nxt_s;
`endif

    approx_mul8u u_core (
        .x (core_in_s.x),
        .y (core_in_s.y),
        .z (core_z_s)
    );

    // Result stage and pointer next state
    always_comb begin
        last_grant_nxt_s = last_grant_r;
        out_valid_nxt_s  = out_valid_r;
        out_z_nxt_s      = out_z_r;
        out_id_nxt_s     = out_id_r;
        if (accept_s) begin
            last_grant_nxt_s = gnt_idx_s;
        end else begin
            last_grant_nxt_s = last_grant_r;
        end
        if (result_can_s) begin
            out_valid_nxt_s = core_valid_s;
            if (core_valid_s) begin
                out_z_nxt_s  = core_z_s;
                out_id_nxt_s = ID_W'(core_in_s.id);
            end else begin
                out_z_nxt_s  = out_z_r;
                out_id_nxt_s = out_id_r;
            end
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Result, pointer and busy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= ID_W'(NUM_REQ - 1);
            out_valid_r  <= 1'b0;
            out_z_r      <= {PROD_W{1'b0}};
            out_id_r     <= {ID_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            last_grant_r <= last_grant_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_z_r      <= out_z_nxt_s;
            out_id_r     <= out_id_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_z     = out_z_r;
    assign out_id    = out_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Directed-vector and scoreboard bench for approx_mul_arbiter (either build).
module tb_approx_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
`ifdef APPROX_MUL_ARBITER_PIPE_EN
    localparam int LAT = 2;
    localparam logic [3:0] BP_NEXT0 = 4'b0010;
    localparam logic [3:0] BP_NEXT1 = 4'b0100;
`else
    localparam int LAT = 1;
    localparam logic [3:0] BP_NEXT0 = 4'b0100;
    localparam logic [3:0] BP_NEXT1 = 4'b0010;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_x;
    logic [NUM_REQ*8-1:0] req_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_z;
    logic [ID_W-1:0]      out_id;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;

    approx_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_id(out_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_z(input logic [7:0] x, input logic [7:0] y);
        int exact;
        int low;
        exact = int'(x) * int'(y);
        low   = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if ((i + j) < 4 && x[i] && y[j]) low += (1 << (i + j));
        return 16'(exact - low);
    endfunction

    typedef struct {
        logic [ID_W-1:0] id;
        logic [15:0]     z;
    } sb_t;
    sb_t sbq[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got id %0d z 0x%0h with no outstanding request", out_id, out_z);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("sb_id", 32'(out_id), 32'(e.id));
                    chk("sb_z", 32'(out_z), 32'(e.z));
                end
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && req_ready[i])
                    sbq.push_back('{id: ID_W'(i), z: model_z(req_x[i*8 +: 8], req_y[i*8 +: 8])});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        int          id;
        logic [15:0] z;
    } vec_t;
    vec_t vec[10];

    initial begin
        int lat;
        logic [3:0] one_r;
        vec[0] = '{8'h80, 8'h01, 0, 16'h0080};
        vec[1] = '{8'h01, 8'h01, 1, 16'h0000};
        vec[2] = '{8'h40, 8'h02, 2, 16'h0080};
        vec[3] = '{8'hFF, 8'hFF, 3, 16'hFDD0};
        vec[4] = '{8'h0F, 8'h0F, 0, 16'h00B0};
        vec[5] = '{8'h03, 8'h03, 1, 16'h0000};
        vec[6] = '{8'h10, 8'h01, 2, 16'h0010};
        vec[7] = '{8'h08, 8'h01, 3, 16'h0000};
        vec[8] = '{8'h00, 8'hFF, 0, 16'h0000};
        vec[9] = '{8'hAA, 8'h55, 1, 16'h3860};

        rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = 4'hF;
        #1 chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;

        // Directed single-request vectors
        for (int v = 0; v < 10; v++) begin
            req_x = '0; req_y = '0;
            req_x[vec[v].id*8 +: 8] = vec[v].x;
            req_y[vec[v].id*8 +: 8] = vec[v].y;
            one_r = 4'b0001;
            req_valid = one_r << vec[v].id;
            out_ready = 1'b1;
            @(negedge clk);
            chk("tbl_ready", 32'(req_ready), 32'(req_valid));
            tick();
            req_valid = '0;
            lat = 0;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                if (out_valid) begin
                    lat = n;
                    break;
                end
            end
            chk("tbl_latency", 32'(lat), 32'(LAT));
            chk("tbl_z", 32'(out_z), 32'(vec[v].z));
            chk("tbl_id", 32'(out_id), 32'(vec[v].id));
            tick();
        end

        // Lone requester is granted every cycle
        req_x = 32'h00_5A_00_00; req_y = 32'h00_C3_00_00;
        req_valid = 4'b0100; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("single_ready", 32'(req_ready), 32'h4);
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        // Round robin with all requesters active
        do_reset();
        req_x = 32'h44_33_22_11; req_y = 32'h05_06_07_08;
        req_valid = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            one_r = 4'b0001;
            chk("rr_ready", 32'(req_ready), 32'(one_r << (c % NUM_REQ)));
            if (c >= LAT) chk("rr_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        // Backpressure with requesters 1 and 2
        do_reset();
        req_x = 32'h00_77_12_00; req_y = 32'h00_21_34_00;
        req_valid = 4'b0110; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_first_grant", 32'(req_ready), 32'h2);
        for (int k = 0; k < 4; k++) begin
            if (req_ready == '0) break;
            tick();
            @(negedge clk);
        end
        chk("bp_full_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_ready_low", 32'(req_ready), 32'd0);
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_z_held", 32'(out_z), 32'h03A0);
            chk("bp_id_held", 32'(out_id), 32'd1);
            tick();
            @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume0", 32'(req_ready), 32'(BP_NEXT0));
        tick();
        @(negedge clk);
        chk("bp_resume1", 32'(req_ready), 32'(BP_NEXT1));
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset with entries in flight
        do_reset();
        req_x = 32'h9C_8B_7A_69; req_y = 32'h13_24_35_46;
        req_valid = 4'hF; out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_pre_full", 32'(out_valid), 32'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_no_stale", 32'(out_valid), 32'd0);
        chk("rst_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        chk("rst_post_latency", 32'(lat), 32'(LAT));
        chk("rst_post_id", 32'(out_id), 32'd0);
        tick();

        // Random traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_x     = $urandom;
            req_y     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rand_ready_onehot",
                32'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0)), 32'd1);
            tick();
        end
        req_valid = '0;
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("drain_sb_empty", 32'(sbq.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
